// File: rtl/glb_stream_ingress.sv
// Receive stage behind the GLB write stream source: buffers 17-bit tokens in a
// small FIFO, forwards them unchanged, classifies/counts them and flags completion.
module glb_stream_ingress #(
  parameter int DEPTH  = 4,
  parameter int TX_NUM = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [16:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [16:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic [CNT_W-1:0] data_count,
  output logic [CNT_W-1:0] stop_count,
  output logic             err_illegal
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DSW = $clog2(TX_NUM + 1);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISHED} state_t;

  state_t           state;
  logic             armed;
  logic [16:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      occ;
  logic [16:0]      last_data;
  logic [CNT_W-1:0] data_cnt;
  logic [CNT_W-1:0] stop_cnt;
  logic [DSW-1:0]   done_seen;
  logic             err_q;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             is_data;
  logic             is_stop;
  logic             is_done;
  logic             is_illegal;
  logic             final_done;
  logic             drain_empty;

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = (state == RUN) && !full && !flush;
  assign out_valid = !empty && !flush;
  assign out_data  = empty ? last_data : mem[rd_ptr[AW-1:0]];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign is_data    = !in_data[16];
  assign is_stop    = in_data[16] && (in_data[9:8] == 2'b00);
  assign is_done    = in_data[16] && (in_data[9:8] == 2'b01) && (in_data[7:0] == 8'd0);
  assign is_illegal = in_data[16] && !is_stop && !is_done;

  assign final_done  = push && is_done && (done_seen == DSW'(TX_NUM - 1));
  // The drain completes on the edge that pops the last buffered token.
  assign drain_empty = empty || ((occ == PTR_ONE) && pop);

  assign done        = (state == FINISHED);
  assign data_count  = data_cnt;
  assign stop_count  = stop_cnt;
  assign err_illegal = err_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Control, pointers and counters; flush clears like reset but also arms RUN.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      armed     <= !rst;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= '0;
      data_cnt  <= '0;
      stop_cnt  <= '0;
      done_seen <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_data <= out_data;
      end
      if (push && is_data && (data_cnt != '1)) data_cnt <= data_cnt + CNT_W'(1);
      if (push && is_stop && (stop_cnt != '1)) stop_cnt <= stop_cnt + CNT_W'(1);
      if (push && is_done) done_seen <= done_seen + DSW'(1);
      if (push && is_illegal) err_q <= 1'b1;
      case (state)
        IDLE:     if (armed) state <= RUN;
        RUN:      if (final_done) state <= DRAIN;
        DRAIN:    if (drain_empty) state <= FINISHED;
        FINISHED: state <= FINISHED;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
